// File: rtl/alu_pipe.sv
// Registered datapath ALU: one operation per valid/ready handshake, result and flags
// held in a single output register; MUL runs as a WIDTH-cycle shift-add sequence.
module alu_pipe #(
    parameter int WIDTH      = 16,
    parameter bit SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    input  logic [2:0]       opcod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             Cout,
    output logic             V,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               cout_q, cout_d;
    logic               v_q, v_d;
    logic               lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
    logic               out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2:0]         cmp_q, cmp_d;

    logic               lt_w, eq_w, gt_w;
    logic [WIDTH:0]     add_w, sub_w;
    logic [2*WIDTH-1:0] acc_step;
    logic               accept;

    always_comb begin
        eq_w = (X == Y);
        if (SIGNED_CMP) lt_w = ($signed(X) < $signed(Y));
        else            lt_w = (X < Y);
        gt_w = !lt_w && !eq_w;
    end

    assign add_w    = {1'b0, X} + {1'b0, Y} + {{WIDTH{1'b0}}, Cin};
    assign sub_w    = {1'b0, X} + {1'b0, ~Y} + {{WIDTH{1'b0}}, 1'b1};
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Accept is allowed in the same cycle the held result drains, so there is no bubble.
    assign in_ready = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    assign out       = out_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign lt        = lt_q;
    assign eq        = eq_q;
    assign gt        = gt_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == S_MUL);

    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        cout_d      = cout_q;
        v_d         = v_q;
        lt_d        = lt_q;
        eq_d        = eq_q;
        gt_d        = gt_q;
        out_valid_d = out_valid_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        cmp_d       = cmp_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (opcod == 3'd7) begin
                        mcand_d  = {{WIDTH{1'b0}}, X};
                        mplier_d = Y;
                        acc_d    = '0;
                        cnt_d    = '0;
                        cmp_d    = {lt_w, eq_w, gt_w};
                        state_d  = S_MUL;
                    end else begin
                        out_valid_d = 1'b1;
                        lt_d        = lt_w;
                        eq_d        = eq_w;
                        gt_d        = gt_w;
                        cout_d      = 1'b0;
                        v_d         = 1'b0;
                        case (opcod)
                            3'd0: begin
                                out_d  = add_w[WIDTH-1:0];
                                cout_d = add_w[WIDTH];
                                v_d    = (X[WIDTH-1] == Y[WIDTH-1]) && (add_w[WIDTH-1] != X[WIDTH-1]);
                            end
                            3'd1: begin
                                out_d  = sub_w[WIDTH-1:0];
                                cout_d = sub_w[WIDTH];
                                v_d    = (X[WIDTH-1] != Y[WIDTH-1]) && (sub_w[WIDTH-1] != X[WIDTH-1]);
                            end
                            3'd2:    out_d = X & Y;
                            3'd3:    out_d = X | Y;
                            3'd4:    out_d = {{(WIDTH-1){1'b0}}, lt_w};
                            3'd5:    out_d = {{(WIDTH-1){1'b0}}, eq_w};
                            3'd6:    out_d = X ^ Y;
                            default: out_d = '0;
                        endcase
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_d       = acc_step[WIDTH-1:0];
                    cout_d      = |acc_step[2*WIDTH-1:WIDTH];
                    v_d         = 1'b0;
                    {lt_d, eq_d, gt_d} = cmp_q;
                    out_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            lt_q        <= 1'b0;
            eq_q        <= 1'b0;
            gt_q        <= 1'b0;
            out_valid_q <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            cmp_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
            lt_q        <= lt_d;
            eq_q        <= eq_d;
            gt_q        <= gt_d;
            out_valid_q <= out_valid_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            cmp_q       <= cmp_d;
        end
    end
endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: unsigned- and signed-compare instances share one stimulus stream;
// expected {out,Cout,V,lt,eq,gt} words are queued at drive time and popped on each result.
module tb_alu_pipe;
    localparam int W  = 16;
    localparam int EW = W + 5;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] X = '0, Y = '0;
    logic         Cin = 1'b0;
    logic [2:0]   opcod = '0;

    logic         in_ready_u, out_valid_u, cout_u, v_u, lt_u, eq_u, gt_u, busy_u;
    logic         in_ready_s, out_valid_s, cout_s, v_s, lt_s, eq_s, gt_s, busy_s;
    logic [W-1:0] out_u, out_s;
    logic [EW-1:0] obs_u, obs_s, last_u, last_s, snap;

    logic [EW-1:0] exp_u[$];
    logic [EW-1:0] exp_s[$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign obs_u = {out_u, cout_u, v_u, lt_u, eq_u, gt_u};
    assign obs_s = {out_s, cout_s, v_s, lt_s, eq_s, gt_s};

    alu_pipe #(.WIDTH(W), .SIGNED_CMP(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_u),
        .X(X), .Y(Y), .Cin(Cin), .opcod(opcod),
        .out_valid(out_valid_u), .out_ready(out_ready), .out(out_u),
        .Cout(cout_u), .V(v_u), .lt(lt_u), .eq(eq_u), .gt(gt_u), .busy(busy_u)
    );

    alu_pipe #(.WIDTH(W), .SIGNED_CMP(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .X(X), .Y(Y), .Cin(Cin), .opcod(opcod),
        .out_valid(out_valid_s), .out_ready(out_ready), .out(out_s),
        .Cout(cout_s), .V(v_s), .lt(lt_s), .eq(eq_s), .gt(gt_s), .busy(busy_s)
    );

    function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic cin, input logic [2:0] op, input bit sc);
        logic [31:0]  s;
        logic [W-1:0] r;
        logic         c, v, l, e, g;
        e = (x == y);
        l = sc ? ($signed(x) < $signed(y)) : (x < y);
        g = !l && !e;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = 32'(x) + 32'(y) + 32'(cin);
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1: begin
                r = x - y;
                c = (x >= y);
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd2: r = x & y;
            3'd3: r = x | y;
            3'd4: r = l ? 16'd1 : 16'd0;
            3'd5: r = e ? 16'd1 : 16'd0;
            3'd6: r = x ^ y;
            default: begin
                s = 32'(x) * 32'(y);
                r = s[W-1:0];
                c = (s[31:16] != 16'd0);
            end
        endcase
        return {r, c, v, l, e, g};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Presents one operation at a negedge and holds it until accepted.
    task automatic drive_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic cin);
        int n;
        @(negedge clk);
        in_valid = 1'b1; opcod = op; X = x; Y = y; Cin = cin;
        exp_u.push_back(model(x, y, cin, op, 1'b0));
        exp_s.push_back(model(x, y, cin, op, 1'b1));
        #1;
        n = 0;
        while (!in_ready_u && n < 64) begin
            @(negedge clk); #1;
            n++;
        end
        if (!in_ready_u) begin
            checks++; errors++;
            $error("FAIL accept_timeout observed=in_ready0 expected=in_ready1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic compare_now(input string tag);
        logic [EW-1:0] eu, es;
        if (exp_u.size() == 0 || exp_s.size() == 0) begin
            checks++; errors++;
            $error("FAIL %s observed=result expected=empty_scoreboard", tag);
            return;
        end
        eu = exp_u.pop_front();
        es = exp_s.pop_front();
        last_u = obs_u;
        last_s = obs_s;
        check({tag, "_u"}, obs_u, eu);
        check({tag, "_s"}, obs_s, es);
    endtask

    task automatic collect(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (!(out_valid_u && out_valid_s) && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!(out_valid_u && out_valid_s)) begin
            checks++; errors++;
            $error("FAIL %s_timeout observed=out_valid0 expected=out_valid1", tag);
            if (exp_u.size() > 0) void'(exp_u.pop_front());
            if (exp_s.size() > 0) void'(exp_s.pop_front());
            return;
        end
        compare_now(tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [2:0] op;
        logic [W-1:0] a, b;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {out_valid_u, busy_u, in_ready_u, obs_u}, '0);
        check("rst_outputs_s", {out_valid_s, busy_s, in_ready_s, obs_s}, '0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", in_ready_u, 1'b1);

        // ADD wrap with carry
        drive_op(3'd0, 16'hFFFF, 16'h0001, 1'b0);
        collect("add_wrap");
        check("add_wrap_lit", last_u, {16'h0000, 1'b1, 1'b0, 3'b001});

        // SUB with signed overflow
        drive_op(3'd1, 16'h8000, 16'h0001, 1'b0);
        collect("sub_ovf");
        check("sub_ovf_lit_s", last_s, {16'h7FFF, 1'b1, 1'b1, 3'b100});

        drive_op(3'd0, 16'h7FFF, 16'h0000, 1'b1);
        collect("add_cin");
        drive_op(3'd4, 16'd3, 16'd5, 1'b0);
        collect("slt_3_5");
        check("slt_lit", last_u[EW-1:5], 16'd1);
        drive_op(3'd4, 16'hFFFF, 16'd1, 1'b0);
        collect("slt_neg");
        drive_op(3'd5, 16'h1234, 16'h1234, 1'b0);
        collect("seq_eq");
        check("seq_eq_lit", last_u, {16'd1, 1'b0, 1'b0, 3'b010});
        drive_op(3'd5, 16'd1, 16'd2, 1'b0);
        collect("seq_ne");
        check("seq_ne_lit", last_u[EW-1:5], 16'd0);

        // Random single-cycle operations
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 6));
            a  = 16'($urandom_range(0, 65535));
            b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom_range(0, 65535));
            drive_op(op, a, b, 1'($urandom_range(0, 1)));
            collect("rand");
        end

        // MUL latency and busy window
        drive_op(3'd7, 16'h0123, 16'h0010, 1'b0);
        n = 0;
        @(negedge clk);
        while (busy_u && n < 40) begin
            check("mul_busy_blocks", {in_ready_u, out_valid_u}, 2'b00);
            n++;
            @(negedge clk);
        end
        check("mul_busy_cycles", n, 16);
        check("mul_done_valid", out_valid_u, 1'b1);
        collect("mul_a");
        check("mul_a_lit", last_u[EW-1:4], {16'h1230, 1'b0});
        drive_op(3'd7, 16'h0100, 16'h0100, 1'b0);
        collect("mul_ovf");
        check("mul_ovf_lit", last_u[EW-1:4], {16'h0000, 1'b1});
        drive_op(3'd7, 16'hFFFF, 16'hFFFF, 1'b0);
        collect("mul_max");

        // Back-pressure hold, then drain together with a new accept
        drive_op(3'd0, 16'h1234, 16'h1111, 1'b0);
        @(negedge clk);
        snap = obs_u;
        in_valid = 1'b1; opcod = 3'd6; X = 16'h00FF; Y = 16'h0F0F; Cin = 1'b0;
        repeat (5) begin
            #1;
            check("hold_stable", {obs_u, in_ready_u, out_valid_u}, {snap, 1'b0, 1'b1});
            @(negedge clk);
        end
        compare_now("bp_add");
        exp_u.push_back(model(16'h00FF, 16'h0F0F, 1'b0, 3'd6, 1'b0));
        exp_s.push_back(model(16'h00FF, 16'h0F0F, 1'b0, 3'd6, 1'b1));
        out_ready = 1'b1;
        #1;
        check("bp_in_ready", in_ready_u, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("bp_no_bubble", out_valid_u, 1'b1);
        check("bp_xor_lit", out_u, 16'h0FF0);
        collect("bp_xor");
        #1;
        check("drained", out_valid_u, 1'b0);

        // Reset in the middle of a multiply
        drive_op(3'd7, 16'h0F0F, 16'h0303, 1'b0);
        void'(exp_u.pop_back());
        void'(exp_s.pop_back());
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midmul_rst", {busy_u, out_valid_u, out_u, in_ready_u}, '0);
        check("midmul_rst_s", {busy_s, out_valid_s, out_s}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(3'd0, 16'h0102, 16'h0304, 1'b0);
        collect("post_rst_add");
        check("post_rst_add_lit", last_u[EW-1:5], 16'h0406);

        check("scoreboard_empty", exp_u.size() + exp_s.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the 16-bit datapath ALU.
- Accepts one operation per valid/ready handshake and returns the result, carry, overflow and compare flags from a single output register held until consumed.
- Adds XOR, a clean set-on-equal and a multi-cycle shift-add multiply with a busy state machine.
- Sits between register-file read and write-back in the datapath.

Parameters:
- WIDTH, 16: operand and result width in bits, minimum 4.
- SIGNED_CMP, 0: 1 makes lt/gt/SLT compare two's-complement; 0 makes them compare unsigned.

Ports:
- clk  in  1  rising-edge clock, the block's only clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands and opcode are valid this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- X  in  WIDTH  operand A.
- Y  in  WIDTH  operand B.
- Cin  in  1  carry-in, used by ADD only.
- opcod  in  3  operation select.
- out_valid  out  1  result register holds an unconsumed result.
- out_ready  in  1  consumer takes the result this cycle.
- out  out  WIDTH  result.
- Cout  out  1  carry/no-borrow (ADD/SUB) or multiply overflow (MUL).
- V  out  1  signed overflow (ADD/SUB only).
- lt, eq, gt  out  1 each  comparison of the accepted X against the accepted Y.
- busy  out  1  multiply in progress.

Behaviour:
- Reset: synchronous, active-low, sampled on the rising edge of clk. While rst_n=0 at an edge, state returns to IDLE and all of out, Cout, V, lt, eq, gt, out_valid and busy are forced to 0. Any in-flight multiply is abandoned with no result. in_ready is 0 while rst_n=0.
- Accept: an operation is taken when in_valid and in_ready are both 1 at a clock edge.
- in_ready rule: in_ready = (state==IDLE) && (!out_valid || out_ready), combinational. This permits a back-to-back accept in the same cycle the previous result drains.
- opcod 0, ADD: {Cout,out} = X+Y+Cin. V=1 when the operands have equal sign and the result sign differs.
- opcod 1, SUB: {Cout,out} = X+~Y+1, so Cout=1 means no borrow. Cin is ignored. V=1 when the operand signs differ and the result sign differs from X.
- opcod 2, AND: out = X&Y.
- opcod 3, OR: out = X|Y.
- opcod 4, SLT: out = lt ? 1 : 0, zero-extended.
- opcod 5, SEQ: out = eq ? 1 : 0, zero-extended.
- opcod 6, XOR: out = X^Y.
- Flags for opcodes 2–6: Cout=0, V=0.
- Latency for opcodes 0–6: one cycle. Accepted at edge N, out_valid=1 after edge N.
- opcod 7, MUL: operands are latched and the FSM goes IDLE→MUL; busy=1, in_ready=0, out_valid=0.
  - Each MUL cycle: if the multiplier LSB is 1, add the shifted multiplicand into a 2*WIDTH accumulator; then shift.
  - After exactly WIDTH cycles in MUL: out = low WIDTH bits, Cout = OR of the high WIDTH bits (unsigned overflow), V=0. out_valid=1, FSM returns to IDLE, busy=0.
  - Latency is WIDTH+1 edges from accept to out_valid.
- lt/eq/gt: computed from the accepted X,Y for every opcode, including MUL, and registered with the result. Exactly one of them is 1.
- Hold: while out_valid=1 and out_ready=0, all outputs are stable and no new operation is accepted.
- Drain: out_valid=1 && out_ready=1 with no new accept clears out_valid. Other outputs may keep their last value.
- Simultaneous drain and accept: the new result overwrites the register and out_valid stays 1. There is no bubble.
- in_valid while not ready: ignored. The source must hold its data until accepted.
- Arithmetic wraps modulo 2^WIDTH. There is no saturation.

Test Plan:
- WIDTH=16; ADD X=0xFFFF, Y=0x0001, Cin=0 -> one cycle later out=0x0000, Cout=1, V=0, lt=0, gt=1 (unsigned).
- SUB X=0x8000, Y=0x0001 -> out=0x7FFF, Cout=1, V=1; with SIGNED_CMP=1, lt=1.
- MUL X=0x0123, Y=0x0010 -> busy=1 and in_ready=0 for 16 cycles, then out=0x1230, Cout=0, out_valid on edge 17; MUL X=0x0100, Y=0x0100 -> out=0x0000, Cout=1.
- Back-pressure: ADD result held with out_ready=0 for 5 cycles -> outputs stable, in_ready=0; raise out_ready together with in_valid on XOR 0x00FF^0x0F0F -> next cycle out=0x0FF0, out_valid stays 1.
- SLT/SEQ: X=3, Y=5 -> SLT out=1; SEQ X=Y=0x1234 -> out=1, eq=1; SEQ X=1, Y=2 -> out=0.
- Reset mid-multiply: rst_n=0 at cycle 8 of MUL -> next edge busy=0, out_valid=0, out=0; first ADD after release completes normally.
